// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Valid/ready byte stream from the UART receive FIFO to its consumer.
//   rx_data  : head-of-FIFO byte, meaningful only while rx_valid=1
//   rx_valid : FIFO holds at least one byte
//   rx_ready : consumer takes rx_data when rx_valid && rx_ready
//   master   : the receiver (drives data/valid)
//   slave    : the consumer (drives ready)
interface uart_rx_fifo_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver (LSB first) feeding a first-word-fall-through FIFO of
//   2**DEPTH_FIFO bytes, with sticky overrun / framing-error flags.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   uart_rxd  : serial input, idle high, asynchronous to clk
//   rx_if     : byte stream out (rx_data / rx_valid / rx_ready)
//   overrun   : sticky, a completed byte was dropped because the FIFO was full
//   frame_err : sticky, a stop bit was sampled low
//   clear_err : synchronous clear of both flags (a same-cycle set wins)
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 100800000,
    parameter int unsigned SCLK_HZ    = 115200,
    parameter int unsigned DEPTH_FIFO = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rxd,
    uart_rx_fifo_if.master        rx_if,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  clear_err
);

    localparam int unsigned DIV     = CLK_HZ / SCLK_HZ;
    localparam int unsigned HALF    = DIV / 2;
    localparam int unsigned CNT_W   = $clog2(DIV + 1);
    localparam int unsigned ENTRIES = 1 << DEPTH_FIFO;

    localparam logic [CNT_W-1:0]    DIV_M1   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]    HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [DEPTH_FIFO:0] CNT_FULL = (DEPTH_FIFO + 1)'(ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; rxs_prev holds the previous synchronised sample
    // so a start bit is recognised only on a genuine high-to-low edge.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;
    logic rxs_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= uart_rxd;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             push;
    logic             frame_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        push         = 1'b0;
        frame_set    = 1'b0;

        case (state)
            S_IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_next = S_START;
                    cnt_next   = HALF_M1;
                end
            end

            // Re-check the line half a bit in; a high level is a glitch.
            S_START: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        state_next   = S_DATA;
                        cnt_next     = DIV_M1;
                        bit_idx_next = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            S_DATA: begin
                if (cnt == '0) begin
                    shreg_next[bit_idx] = rxs;
                    cnt_next            = DIV_M1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            S_STOP: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FWFT FIFO. A push into a full FIFO still succeeds when the head is
    // popped in the same cycle: the write lands in the slot being freed.
    // ------------------------------------------------------------------
    logic [7:0]            mem [ENTRIES];
    logic [DEPTH_FIFO-1:0] wr_ptr;
    logic [DEPTH_FIFO-1:0] rd_ptr;
    logic [DEPTH_FIFO:0]   count;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  ovr_set;

    assign full    = (count == CNT_FULL);
    assign pop     = rx_if.rx_valid && rx_if.rx_ready;
    assign push_ok = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    assign rx_if.rx_valid = (count != '0);
    assign rx_if.rx_data  = rx_if.rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a set event outranks clear_err.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end

            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule
